// File: rtl/viterbi_traceback_ctrl.sv
// Viterbi traceback controller: buffers ACS decisions for one frame, traces back
// from the supplied best state, then streams decoded bits in transmission order.
module viterbi_traceback_ctrl #(
  parameter int FRAME_MAX = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [3:0] i_decisions,
  input  logic       i_last,
  input  logic [1:0] i_best_state,
  output logic       o_bit,
  output logic       o_bit_valid,
  input  logic       i_bit_ready,
  output logic       o_bit_last,
  output logic       o_done
);
  localparam int AW = $clog2(FRAME_MAX);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FILL, TRACE, OUTPUT} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, r_ptr, r_rd, r_n;
  logic [1:0]      r_tb_state;
  logic            r_done;
  logic [3:0]      r_dec [FRAME_MAX];
  logic [FRAME_MAX-1:0] r_bitbuf;

  logic       w_accept, w_end_fill, w_take, w_last_bit;
  logic [3:0] w_dec_rd;

  assign w_accept   = i_valid && (r_state == FILL);
  assign w_end_fill = w_accept && (i_last || (r_cnt == CW'(FRAME_MAX - 1)));
  assign w_take     = o_bit_valid && i_bit_ready;
  assign w_last_bit = (r_rd == r_n - CW'(1));
  assign w_dec_rd   = r_dec[r_ptr[AW-1:0]];

  always_comb begin
    w_next      = r_state;
    o_ready     = 1'b0;
    o_bit_valid = 1'b0;
    case (r_state)
      FILL: begin
        o_ready = 1'b1;
        if (w_end_fill) w_next = TRACE;
      end
      TRACE:  if (r_ptr == '0) w_next = OUTPUT;
      OUTPUT: begin
        o_bit_valid = 1'b1;
        if (w_take && w_last_bit) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
  end

  assign o_bit      = o_bit_valid & r_bitbuf[r_rd[AW-1:0]];
  assign o_bit_last = o_bit_valid & w_last_bit;
  assign o_done     = r_done;

  // Storage arrays carry no reset: only indices below n are ever read back.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_dec[r_cnt[AW-1:0]] <= i_decisions;
    if (r_state == TRACE) r_bitbuf[r_ptr[AW-1:0]] <= r_tb_state[1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= FILL;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_rd       <= '0;
      r_n        <= '0;
      r_tb_state <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        FILL: if (w_accept) begin
          r_cnt <= r_cnt + CW'(1);
          if (w_end_fill) begin
            r_tb_state <= i_best_state;
            r_n        <= r_cnt + CW'(1);
            r_ptr      <= r_cnt;
          end
        end
        TRACE: begin
          // Step to the predecessor {s[0], d[s]} of the current survivor state.
          r_tb_state <= {r_tb_state[0], w_dec_rd[r_tb_state]};
          r_ptr      <= r_ptr - CW'(1);
          if (r_ptr == '0) r_rd <= '0;
        end
        OUTPUT: if (w_take) begin
          if (w_last_bit) begin
            r_done <= 1'b1;
            r_cnt  <= '0;
            r_rd   <= '0;
          end else begin
            r_rd <= r_rd + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
